// File: rtl/dist_search_ctrl.sv
// dist_search_ctrl: initiator-side sequencer for the distance calculator.
// It latches a target matrix, then walks the candidate ROM from index 0 to
// NUM_CAND-1. For each candidate it loads the ROM word, pulses calc_ready,
// and waits for calc_finished. It keeps the smallest dist2 seen and the
// index of that candidate.
// Optional feature macro: DIST_EARLY_EXIT_EN. When it is defined, the
// search ends early once a returned dist2 is at or below EXIT_THRESH, and
// the early_exit output flags that case.
module dist_search_ctrl #(
  parameter int NUM_CAND = 16,
  parameter int IDX_W    = 4
`ifdef DIST_EARLY_EXIT_EN
  ,
  parameter logic [37:0] EXIT_THRESH = 38'd0
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [18:0]      mtx_target [0:1][0:1][0:1],
  output logic [IDX_W-1:0]        cand_idx,
  input  logic signed [18:0]      cand_mtx [0:1][0:1][0:1],
  output logic signed [18:0]      mtx_a [0:1][0:1][0:1],
  output logic signed [18:0]      mtx_b [0:1][0:1][0:1],
  output logic                    calc_ready,
  input  logic                    calc_finished,
  input  logic [37:0]             dist2,
  output logic [IDX_W-1:0]        best_idx,
  output logic [37:0]             best_dist,
  output logic                    busy,
`ifdef DIST_EARLY_EXIT_EN
  output logic                    early_exit,
`endif
  output logic                    done
);

  typedef logic signed [18:0] mtx_t [0:1][0:1][0:1];

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  mtx_t             mtx_a_q, mtx_a_d;
  mtx_t             mtx_b_q, mtx_b_d;
  logic             calc_ready_q, calc_ready_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [37:0]      best_dist_q, best_dist_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIST_EARLY_EXIT_EN
  logic             exit_hit_q, exit_hit_d;
  logic             early_exit_q, early_exit_d;
`endif

  // Next-state and next-output logic for the search sequencer.
  always_comb begin
    state_d      = state_q;
    cand_idx_d   = cand_idx_q;
    mtx_a_d      = mtx_a_q;
    mtx_b_d      = mtx_b_q;
    calc_ready_d = 1'b0;
    best_idx_d   = best_idx_q;
    best_dist_d  = best_dist_q;
    busy_d       = busy_q;
    done_d       = done_q;
`ifdef DIST_EARLY_EXIT_EN
    exit_hit_d   = exit_hit_q;
    early_exit_d = early_exit_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          mtx_a_d     = mtx_target;
          cand_idx_d  = '0;
          best_dist_d = '1;
          best_idx_d  = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
`ifdef DIST_EARLY_EXIT_EN
          exit_hit_d   = 1'b0;
          early_exit_d = 1'b0;
`endif
          state_d     = FETCH;
        end
      end

      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        mtx_b_d      = cand_mtx;
        calc_ready_d = 1'b1;
        state_d      = ISSUE;
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (calc_finished) begin
          if (dist2 < best_dist_q) begin
            best_dist_d = dist2;
            best_idx_d  = cand_idx_q;
          end
`ifdef DIST_EARLY_EXIT_EN
          if (dist2 <= EXIT_THRESH) begin
            exit_hit_d = 1'b1;
            state_d    = DONE;
          end else
`endif
          if (cand_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cand_idx_d = cand_idx_q + 1'b1;
            state_d    = FETCH;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef DIST_EARLY_EXIT_EN
        early_exit_d = exit_hit_q;
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any search and returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cand_idx_q   <= '0;
      mtx_a_q      <= '{default: 19'sd0};
      mtx_b_q      <= '{default: 19'sd0};
      calc_ready_q <= 1'b0;
      best_idx_q   <= '0;
      best_dist_q  <= '1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef DIST_EARLY_EXIT_EN
      exit_hit_q   <= 1'b0;
      early_exit_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cand_idx_q   <= cand_idx_d;
      mtx_a_q      <= mtx_a_d;
      mtx_b_q      <= mtx_b_d;
      calc_ready_q <= calc_ready_d;
      best_idx_q   <= best_idx_d;
      best_dist_q  <= best_dist_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef DIST_EARLY_EXIT_EN
      exit_hit_q   <= exit_hit_d;
      early_exit_q <= early_exit_d;
`endif
    end
  end

  assign cand_idx   = cand_idx_q;
  assign mtx_a      = mtx_a_q;
  assign mtx_b      = mtx_b_q;
  assign calc_ready = calc_ready_q;
  assign best_idx   = best_idx_q;
  assign best_dist  = best_dist_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef DIST_EARLY_EXIT_EN
  assign early_exit = early_exit_q;
`endif

endmodule

// File: tb/tb_dist_search_ctrl.sv
// tb_dist_search_ctrl: directed bench for dist_search_ctrl with NUM_CAND=4.
// Surrounds the sequencer with a one-cycle-latency candidate ROM and a
// distance unit whose finished follows ready by one cycle. One candidate
// can be made to respond slowly. Build with DIST_EARLY_EXIT_EN to exercise
// the early-exit variant.
module tb_dist_search_ctrl;

  localparam int NC = 4;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic signed [18:0] mtx_target [0:1][0:1][0:1];
  logic [IW-1:0]     cand_idx;
  logic signed [18:0] cand_mtx [0:1][0:1][0:1];
  logic signed [18:0] mtx_a [0:1][0:1][0:1];
  logic signed [18:0] mtx_b [0:1][0:1][0:1];
  logic              calc_ready;
  logic              calc_finished = 1'b0;
  logic [37:0]       dist2 = '0;
  logic [IW-1:0]     best_idx;
  logic [37:0]       best_dist;
  logic              busy;
  logic              done;
`ifdef DIST_EARLY_EXIT_EN
  logic              early_exit;
`endif

  int total = 0;
  int bad   = 0;

  logic [37:0]       dtab [0:15];
  int                readyCnt = 0;
  int                slowCand = -1;
  int                holdCnt = 0;
  logic              spurReq = 1'b0;
  logic              orderBad = 1'b0;
  logic              romBad = 1'b0;
  logic              mtxbChanged = 1'b0;
  logic [37:0]       pend = '0;
  logic signed [18:0] heldB = '0;
  int                doneCycle;

  dist_search_ctrl #(
    .NUM_CAND(NC),
    .IDX_W(IW)
`ifdef DIST_EARLY_EXIT_EN
    ,
    .EXIT_THRESH(38'd10)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mtx_target(mtx_target),
    .cand_idx(cand_idx),
    .cand_mtx(cand_mtx),
    .mtx_a(mtx_a),
    .mtx_b(mtx_b),
    .calc_ready(calc_ready),
    .calc_finished(calc_finished),
    .dist2(dist2),
    .best_idx(best_idx),
    .best_dist(best_dist),
    .busy(busy),
`ifdef DIST_EARLY_EXIT_EN
    .early_exit(early_exit),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Candidate ROM: word element = index*16 + position, one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++)
          cand_mtx[i][j][k] <= 19'(int'(cand_idx) * 16 + i * 4 + j * 2 + k);
  end

  // Distance unit: registers the table entry on ready and raises finished a
  // cycle later, or several cycles later for the slow candidate.
  always @(posedge clk) begin
    if (reset) begin
      calc_finished <= 1'b0;
      holdCnt       <= 0;
    end else begin
      calc_finished <= 1'b0;
      if (holdCnt > 0) begin
        if (mtx_b[1][1][1] !== heldB) mtxbChanged = 1'b1;
        if (holdCnt == 1) begin
          calc_finished <= 1'b1;
          dist2         <= pend;
        end
        holdCnt <= holdCnt - 1;
      end
      if (calc_ready) begin
        if (cand_idx != IW'(readyCnt)) orderBad = 1'b1;
        if (mtx_b[0][0][0] != 19'(int'(cand_idx) * 16)) romBad = 1'b1;
        readyCnt = readyCnt + 1;
        heldB <= mtx_b[1][1][1];
        if (int'(cand_idx) == slowCand) begin
          pend    <= dtab[cand_idx];
          holdCnt <= 5;
        end else begin
          calc_finished <= 1'b1;
          dist2         <= dtab[cand_idx];
        end
      end
      if (spurReq) begin
        calc_finished <= 1'b1;
        dist2         <= '0;
      end
    end
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic setTarget(input int base);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++)
          mtx_target[i][j][k] = 19'(base + i * 4 + j * 2 + k);
  endtask

  // Runs one search; optional mid-search start, spurious finished, reset
  // and slow candidate, each keyed to a cycle count after the start cycle.
  task automatic applyStimulus(input logic [37:0] t0, input logic [37:0] t1,
                               input logic [37:0] t2, input logic [37:0] t3,
                               input int midStart, input int spurAt,
                               input int resetAt, input int slowC,
                               output int cyc);
    dtab[0] = t0; dtab[1] = t1; dtab[2] = t2; dtab[3] = t3;
    slowCand    = slowC;
    readyCnt    = 0;
    orderBad    = 1'b0;
    romBad      = 1'b0;
    mtxbChanged = 1'b0;
    @(negedge clk);
    setTarget(100);
    start = 1'b1;
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start   = (n == midStart) || (n == resetAt);
      spurReq = (n == spurAt);
      reset   = (n == resetAt);
      if (n == midStart) setTarget(900);
      if (resetAt > 0 && n == resetAt + 1) break;
      if (done) begin
        cyc = n;
        break;
      end
    end
    start   = 1'b0;
    spurReq = 1'b0;
    reset   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dtab[i] = '0;
    reset   = 1'b1;
    start   = 1'b0;
    setTarget(0);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_best_dist", 64'(best_dist), 64'h3F_FFFF_FFFF);
    checkOutput("rst_best_idx", 64'(best_idx), 64'd0);
    checkOutput("rst_cand_idx", 64'(cand_idx), 64'd0);
    checkOutput("rst_ready", 64'(calc_ready), 64'd0);
    checkOutput("rst_mtx_a", 64'(mtx_a[1][0][1]), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] basic minimum");
    applyStimulus(38'd500, 38'd120, 38'd300, 38'd121, 0, 0, 0, -1, doneCycle);
    checkOutput("basic_done_cycle", 64'(doneCycle), 64'd18);
    checkOutput("basic_best_idx", 64'(best_idx), 64'd1);
    checkOutput("basic_best_dist", 64'(best_dist), 64'd120);
    checkOutput("basic_ready_cnt", 64'(readyCnt), 64'd4);
    checkOutput("basic_order", 64'(orderBad), 64'd0);
    checkOutput("basic_rom", 64'(romBad), 64'd0);
    checkOutput("basic_busy", 64'(busy), 64'd0);
    checkOutput("basic_mtx_a", 64'(mtx_a[1][0][1]), 64'd105);
    checkOutput("basic_mtx_b", 64'(mtx_b[0][1][0]), 64'd50);
`ifdef DIST_EARLY_EXIT_EN
    checkOutput("basic_early_exit", 64'(early_exit), 64'd0);
`endif
    repeat (3) @(negedge clk);
    checkOutput("hold_done", 64'(done), 64'd1);
    checkOutput("hold_best_idx", 64'(best_idx), 64'd1);
    checkOutput("hold_best_dist", 64'(best_dist), 64'd120);

    $display("[TB] ties");
    applyStimulus(38'd50, 38'd50, 38'd50, 38'd50, 0, 0, 0, -1, doneCycle);
    checkOutput("tie_best_idx", 64'(best_idx), 64'd0);
    checkOutput("tie_best_dist", 64'(best_dist), 64'd50);

    $display("[TB] all maximum");
    applyStimulus(38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF, 38'h3F_FFFF_FFFF,
                  0, 0, 0, -1, doneCycle);
    checkOutput("max_best_idx", 64'(best_idx), 64'd0);
    checkOutput("max_best_dist", 64'(best_dist), 64'h3F_FFFF_FFFF);
    checkOutput("max_done_cycle", 64'(doneCycle), 64'd18);

    $display("[TB] slow responder");
    applyStimulus(38'd500, 38'd120, 38'd300, 38'd121, 0, 0, 0, 2, doneCycle);
    checkOutput("slow_done_cycle", 64'(doneCycle), 64'd23);
    checkOutput("slow_best_idx", 64'(best_idx), 64'd1);
    checkOutput("slow_best_dist", 64'(best_dist), 64'd120);
    checkOutput("slow_ready_cnt", 64'(readyCnt), 64'd4);
    checkOutput("slow_mtx_b_stable", 64'(mtxbChanged), 64'd0);

    $display("[TB] start and finished abuse");
    applyStimulus(38'd500, 38'd120, 38'd300, 38'd121, 6, 4, 0, -1, doneCycle);
    checkOutput("abuse_done_cycle", 64'(doneCycle), 64'd18);
    checkOutput("abuse_best_idx", 64'(best_idx), 64'd1);
    checkOutput("abuse_best_dist", 64'(best_dist), 64'd120);
    checkOutput("abuse_ready_cnt", 64'(readyCnt), 64'd4);
    checkOutput("abuse_mtx_a", 64'(mtx_a[1][0][1]), 64'd105);

    $display("[TB] reset during wait");
    applyStimulus(38'd500, 38'd120, 38'd300, 38'd121, 0, 0, 12, -1, doneCycle);
    checkOutput("rstw_busy", 64'(busy), 64'd0);
    checkOutput("rstw_done", 64'(done), 64'd0);
    checkOutput("rstw_best_dist", 64'(best_dist), 64'h3F_FFFF_FFFF);
    checkOutput("rstw_cand_idx", 64'(cand_idx), 64'd0);
    @(negedge clk);
    checkOutput("rstw_idle_busy", 64'(busy), 64'd0);
    applyStimulus(38'd500, 38'd120, 38'd300, 38'd121, 0, 0, 0, -1, doneCycle);
    checkOutput("rerun_done_cycle", 64'(doneCycle), 64'd18);
    checkOutput("rerun_order", 64'(orderBad), 64'd0);
    checkOutput("rerun_best_idx", 64'(best_idx), 64'd1);

    $display("[TB] threshold table");
    applyStimulus(38'd40, 38'd7, 38'd1, 38'd0, 0, 0, 0, -1, doneCycle);
`ifdef DIST_EARLY_EXIT_EN
    checkOutput("exit_done_cycle", 64'(doneCycle), 64'd10);
    checkOutput("exit_best_idx", 64'(best_idx), 64'd1);
    checkOutput("exit_best_dist", 64'(best_dist), 64'd7);
    checkOutput("exit_ready_cnt", 64'(readyCnt), 64'd2);
    checkOutput("exit_flag", 64'(early_exit), 64'd1);
`else
    checkOutput("full_done_cycle", 64'(doneCycle), 64'd18);
    checkOutput("full_best_idx", 64'(best_idx), 64'd3);
    checkOutput("full_best_dist", 64'(best_dist), 64'd0);
    checkOutput("full_ready_cnt", 64'(readyCnt), 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dist_search_ctrl.md
Name: dist_search_ctrl

Overview:
- Initiator-side sequencer for the distance calculator.
- Latches a target matrix and walks a candidate-matrix ROM, index 0 to NUM_CAND-1.
- For each candidate, presents the (target, candidate) pair to the distance unit, pulses its ready, and waits for finished.
- Tracks the minimum returned dist2 and its index, so the compiler's gate-search stage gets the best-matching candidate.

Parameters:
- NUM_CAND, 16: number of candidates searched; legal range 1..2^IDX_W.
- IDX_W, 4: width of the candidate index.
- EXIT_THRESH, 38'd0: early-exit threshold; used only with DIST_EARLY_EXIT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a search; ignored while busy
- mtx_target  in  signed [18:0] [0:1][0:1][0:1]  target matrix; sampled on the accepted start cycle only
- cand_idx  out  IDX_W  candidate ROM address; data is expected on cand_mtx the next cycle
- cand_mtx  in  signed [18:0] [0:1][0:1][0:1]  candidate ROM data, one-cycle read latency
- mtx_a  out  signed [18:0] [0:1][0:1][0:1]  registered target, driven to the distance unit
- mtx_b  out  signed [18:0] [0:1][0:1][0:1]  registered candidate, driven to the distance unit
- calc_ready  out  1  one-cycle pulse to the distance unit
- calc_finished  in  1  completion from the distance unit
- dist2  in  38  unsigned squared distance, valid when calc_finished=1
- best_idx  out  IDX_W  index of the current best candidate
- best_dist  out  38  dist2 of the current best candidate
- busy  out  1  high from the accepted start until done rises
- done  out  1  level; high once the search ends, cleared by the next accepted start

Behaviour:
- Reset values: state=IDLE; cand_idx, mtx_a, mtx_b, best_idx = 0; best_dist = all ones; calc_ready, busy, done = 0.
- Reset has priority over every other input and aborts any search in progress, returning to IDLE.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 → register mtx_target into mtx_a, cand_idx<=0, best_dist<=all ones, best_idx<=0, busy<=1, done<=0 → FETCH.
- FETCH: cand_idx is stable on the port → LOAD.
- LOAD: mtx_b<=cand_mtx → ISSUE.
- ISSUE: calc_ready=1 for exactly this cycle → WAIT.
- mtx_a and mtx_b stay constant from ISSUE until calc_finished is seen.
- WAIT:
  - Stay in WAIT until calc_finished=1.
  - On calc_finished=1: if dist2 < best_dist (unsigned, strict), update best_dist<=dist2 and best_idx<=cand_idx.
  - Ties keep the lower index. Candidate 0 always wins against the all-ones initial value.
  - Then: if cand_idx == NUM_CAND-1 → DONE; otherwise cand_idx<=cand_idx+1 → FETCH.
  - cand_idx never wraps.
- DONE: busy<=0, done<=1 → IDLE (done stays high).
- best_idx and best_dist hold after the search until the next accepted start.
- calc_finished outside WAIT is ignored.
- start outside IDLE is ignored.
- start in the same cycle as reset is ignored.
- Timing with a distance unit whose finished follows ready by one cycle:
  - 4 cycles per candidate (FETCH, LOAD, ISSUE, WAIT).
  - done rises 4*NUM_CAND+2 cycles after the start cycle.
- NUM_CAND=1: a single iteration, then DONE.

Optional Feature:
- Macro: DIST_EARLY_EXIT_EN.
- Defined:
  - In WAIT, if calc_finished=1 and dist2 <= EXIT_THRESH, the best registers update (if strictly better) and the search goes directly to DONE regardless of cand_idx.
  - Adds output early_exit (1 bit, reset 0): set with done when the exit was threshold-triggered, otherwise 0; cleared on the next accepted start.
- Undefined: no comparison against EXIT_THRESH, no early_exit port, and the search always covers all NUM_CAND candidates.

Test Plan:
- Bench models:
  - ROM: returns data at 1-cycle latency.
  - Distance unit: finished = ready delayed 1 cycle; dist2 = table[cand] registered.
- Basic min: NUM_CAND=4, dist table {500,120,300,121}, single start → best_idx=1, best_dist=120, done high exactly 18 cycles after start, 4 calc_ready pulses, cand_idx seen 0..3.
- Ties and first candidate: table {50,50,50,50} → best_idx=0. Table all 38'h3F_FFFF_FFFF → best_idx=0 with best_dist equal to that value.
- Slow responder: delay finished by 5 cycles on candidate 2 → mtx_b stable through WAIT, no extra calc_ready pulse, result unchanged from the basic-min case.
- Protocol abuse and reset:
  - Start pulsed mid-search → ignored.
  - Spurious calc_finished in FETCH → ignored, best unchanged.
  - Reset asserted in WAIT of candidate 2 → next cycle busy=0, done=0, best_dist all ones.
  - A new start then searches from index 0.
- Early exit (macro defined, EXIT_THRESH=10): table {40,7,1,0} → done after candidate 1, best_idx=1, best_dist=7, early_exit=1, only 2 calc_ready pulses. With the macro undefined → best_idx=3, best_dist=0.
